lmac_sync_fifo: RTL
===================

Name: lmac_sync_fifo

Overview:
Parametrised single-clock FIFO for LMAC datapath buffering (TX/RX staging between MAC core stages). It replaces ad-hoc dual-clock FIFOs where both sides share one clock. Adds over the previous generation:
- Registered almost-full/almost-empty thresholds.
- Sticky overflow/underflow error flags.
- Synchronous flush.
- Selectable show-ahead (first-word-fall-through) read mode.

Parameters:
WIDTH, 64, data word width in bits
DEPTH, 16, number of entries; must be a power of 2, >= 4
PTR, 4, log2(DEPTH); pointers and counts are PTR+1 bits
AFULL_THRESH, 12, afull asserted when usedw >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 2, aempty asserted when usedw <= AEMPTY_THRESH (0..DEPTH-1)
SHOWAHEAD, 0, 0 = registered read (normal), 1 = first-word-fall-through

Ports:
clk  in  1  single clock for all logic, rising edge
reset_  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, active high
wren  in  1  write request
datain  in  WIDTH  write data
rden  in  1  read request
dataout  out  WIDTH  read data
full  out  1  usedw == DEPTH
empty  out  1  usedw == 0
afull  out  1  almost full
aempty  out  1  almost empty
usedw  out  PTR+1  occupied entries, 0..DEPTH
ovf  out  1  sticky: write attempted while full
udf  out  1  sticky: read attempted while empty
err_clr  in  1  synchronous clear of ovf/udf (and peak_usedw, see option)
peak_usedw  out  PTR+1  high-water mark (see Optional Feature)

Behaviour:
- Reset (reset_ low, asynchronous):
  - wr_ptr = rd_ptr = 0, usedw = 0.
  - empty = 1, aempty = 1, full = 0, afull = 0 (afull is 1 only if AFULL_THRESH == 0, which is illegal).
  - ovf = udf = 0, dataout = 0, peak_usedw = 0.
- Pointers are PTR+1 bits. Bit PTR is the wrap bit; memory is indexed by [PTR-1:0]. Pointers wrap naturally from 2*DEPTH-1 to 0.
- usedw = wr_ptr - rd_ptr, modulo 2^(PTR+1).
- Accept rules:
  - wr_acc = wren & !full.
  - rd_acc = rden & !empty.
  - Both evaluated on the current registered flags.
  - Simultaneous wr_acc and rd_acc: both pointers advance and usedw is unchanged.
  - At full, a simultaneous rden does NOT allow the write: the write is dropped and ovf sets. At empty, a simultaneous wren does NOT allow the read: udf sets.
- Flags: full, empty, afull, aempty and usedw are registered, computed from the next-state count, and all update on the same edge as the pointers. A write into an empty FIFO deasserts empty one cycle after the accepting edge.
- Error flags:
  - ovf sets on any edge with wren & full; udf sets on any edge with rden & empty.
  - Both hold until err_clr or reset.
  - If err_clr and a set condition occur in the same cycle, the set wins.
- Normal mode (SHOWAHEAD=0):
  - dataout is registered. On rd_acc it loads mem[rd_ptr] and is valid the cycle after the rden edge.
  - Otherwise dataout holds its last value.
  - Write-and-read of the same word is impossible, because a read needs !empty.
- Show-ahead mode (SHOWAHEAD=1):
  - dataout = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - rd_acc pops the head; the next word appears after the edge.
  - A write to an empty FIFO is visible on dataout in the cycle empty deasserts.
- clr:
  - Pointers go to 0, usedw 0, flags to their reset values, dataout to 0.
  - clr has priority over wren/rden in the same cycle; those requests are ignored and do not set ovf/udf.
  - clr does not clear ovf/udf.
  - Memory contents are not cleared.
- Memory: DEPTH x WIDTH register array, written on wr_acc at wr_ptr[PTR-1:0]. No reset on the array.

Optional Feature:
Macro LMAC_FIFO_PEAK_EN.
- Defined: peak_usedw registers max(peak_usedw, next usedw) every cycle. Cleared by reset or err_clr, not by clr. If err_clr coincides with a nonzero next usedw, peak loads that usedw.
- Undefined: peak_usedw is tied to 0 and the comparator is not built. The port stays present so instantiations do not change.

Test Plan:
- Reset, then write 16 words 0x1..0x10 back-to-back -> full=1 and usedw=16 one cycle after the 16th accept; afull=1 from usedw=12; empty deasserts the cycle after the first write.
- At full, assert wren+rden together with datain=0xAA -> usedw drops to 15, ovf=1, and 0xAA is never read out.
- SHOWAHEAD=0: fill with 0x1..0x4, then rden for 4 cycles -> dataout = 0x1,0x2,0x3,0x4 one cycle after each read; a 5th rden -> udf=1, dataout holds 0x4.
- SHOWAHEAD=1: write 0x55 into an empty FIFO -> dataout=0x55 in the cycle empty=0; rden pops -> dataout=0, empty=1.
- Stream 40 words with simultaneous wren/rden at usedw=8 -> usedw stays at 8, data order preserved across two pointer wraps.
- Issue clr mid-stream with wren=1 -> usedw=0, empty=1, ovf unchanged. With LMAC_FIFO_PEAK_EN, peak_usedw retains its pre-clr value until err_clr.

Source files
------------

// File: rtl/lmac_sync_fifo.sv
// lmac_sync_fifo -- single-clock FIFO used to stage TX/RX words between
// LMAC core stages.
//
// Ports
//   clk          rising-edge clock for all logic
//   reset_       asynchronous active-low reset
//   clr          synchronous flush (pointers, count, flags, dataout)
//   wren/datain  write request and write data
//   rden/dataout read request and read data
//   full/empty   registered occupancy flags
//   afull/aempty registered threshold flags (usedw >= AFULL_THRESH,
//                usedw <= AEMPTY_THRESH)
//   usedw        registered number of occupied entries, 0..DEPTH
//   ovf/udf      sticky write-while-full / read-while-empty flags
//   err_clr      synchronous clear of ovf/udf and peak_usedw
//   peak_usedw   high-water mark of usedw
//
// Handshake: a write is accepted on an edge where wren=1 and the
// registered full=0; a read is accepted where rden=1 and the registered
// empty=0. A request against the opposite flag is dropped, never queued,
// and sets the matching sticky error flag. clr outranks both requests.
//
// Build option: define LMAC_FIFO_PEAK_EN to build the peak_usedw tracker;
// otherwise peak_usedw is tied to zero.
//
// SHOWAHEAD=0: dataout is registered and loads the head on a read accept.
// SHOWAHEAD=1: dataout shows the head combinationally, 0 while empty.
module lmac_sync_fifo #(
    parameter int WIDTH         = 64,
    parameter int DEPTH         = 16,
    parameter int PTR           = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter int SHOWAHEAD     = 0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             clr,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [PTR:0]     usedw,
    output logic             ovf,
    output logic             udf,
    input  logic             err_clr,
    output logic [PTR:0]     peak_usedw
);

    localparam logic [PTR:0] DEPTH_C  = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AFULL_C  = (PTR+1)'(AFULL_THRESH);
    localparam logic [PTR:0] AEMPTY_C = (PTR+1)'(AEMPTY_THRESH);
    localparam logic [PTR:0] PTR_ONE  = (PTR+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR:0] wr_ptr, rd_ptr;
    logic [PTR:0] next_wr_ptr, next_rd_ptr, next_used;
    logic         wr_acc, rd_acc;

    // Accepts use the registered flags; clr masks both so a flush cycle
    // neither moves data nor touches memory.
    always_comb begin
        wr_acc      = wren & ~full & ~clr;
        rd_acc      = rden & ~empty & ~clr;
        next_wr_ptr = wr_ptr;
        next_rd_ptr = rd_ptr;
        if (clr) begin
            next_wr_ptr = '0;
            next_rd_ptr = '0;
        end else begin
            if (wr_acc) next_wr_ptr = wr_ptr + PTR_ONE;
            if (rd_acc) next_rd_ptr = rd_ptr + PTR_ONE;
        end
        // The wrap bit makes the modulo difference the true count 0..DEPTH.
        next_used = next_wr_ptr - next_rd_ptr;
    end

    // Storage array: no reset, contents survive clr.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[PTR-1:0]] <= datain;
    end

    // Pointers and flags all derive from the next-state count so they
    // move together on the accepting edge.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= (AFULL_THRESH == 0);
            aempty <= 1'b1;
        end else begin
            wr_ptr <= next_wr_ptr;
            rd_ptr <= next_rd_ptr;
            usedw  <= next_used;
            full   <= (next_used == DEPTH_C);
            empty  <= (next_used == '0);
            afull  <= (next_used >= AFULL_C);
            aempty <= (next_used <= AEMPTY_C);
        end
    end

    // Sticky errors: a set in the same cycle as err_clr wins. A flush
    // cycle ignores the requests, so it cannot set either flag.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (wren & full & ~clr) | (ovf & ~err_clr);
            udf <= (rden & empty & ~clr) | (udf & ~err_clr);
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign dataout = empty ? '0 : mem[rd_ptr[PTR-1:0]];
        end else begin : g_registered
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_)     dout_q <= '0;
                else if (clr)    dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr[PTR-1:0]];
            end
            assign dataout = dout_q;
        end
    endgenerate

`ifdef LMAC_FIFO_PEAK_EN
    // err_clr restarts tracking from the count being entered this edge.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)                    peak_usedw <= '0;
        else if (err_clr)               peak_usedw <= next_used;
        else if (next_used > peak_usedw) peak_usedw <= next_used;
    end
`else
    assign peak_usedw = '0;
`endif

endmodule
